// File: rtl/regfile_lvt_nlane.sv
// rtl/regfile_lvt_nlane.sv - N-lane GPR file with live-value table, clear sequencer and bypass
// One bank per write lane; the LVT selects which bank holds each register's current value.
module regfile_lvt_nlane #(
  parameter int             NLANES  = 3,
  parameter int             NRDPORT = 6,
  parameter int             NREG    = 32,
  parameter int             WIDTH   = 64,
  parameter int             IDW     = 6,
  parameter logic [IDW-1:0] ID_IMM  = 6'h3E,
  parameter logic [IDW-1:0] ID_ZZR  = 6'h3F
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     clrReq,
  output logic                     busy,
  input  logic [NRDPORT*IDW-1:0]   regIdRd,
  output logic [NRDPORT*WIDTH-1:0] regValRd,
  input  logic [NLANES*33-1:0]     regValImm,
  input  logic [NLANES*IDW-1:0]    regIdRn1,
  input  logic [NLANES*WIDTH-1:0]  regValRn1,
  input  logic [NLANES*IDW-1:0]    regIdRn2,
  input  logic [NLANES*WIDTH-1:0]  regValRn2
);

  localparam int AW = $clog2(NREG);
  localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] bank [NLANES][NREG];
  logic [LW-1:0]    lvt  [NREG];
  logic [NLANES-1:0] wr_en;

  assign busy = (state == ST_CLEAR);

  always_comb begin
    wr_en = '0;
    for (int l = 0; l < NLANES; l++) begin
      wr_en[l] = (state == ST_RUN) && !hold && (regIdRn2[l*IDW +: IDW] < IDW'(NREG));
    end
  end

  // Ascending lane loop: the highest writing lane's LVT assignment lands last and wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      for (int r = 0; r < NREG; r++) begin
        lvt[r] <= '0;
      end
    end else if (state == ST_CLEAR) begin
      lvt[cnt] <= '0;
      cnt      <= cnt + 1'b1;
      if (cnt == AW'(NREG - 1)) begin
        state <= ST_RUN;
      end
    end else begin
      if (clrReq) begin
        state <= ST_CLEAR;
        cnt   <= '0;
      end
      for (int l = 0; l < NLANES; l++) begin
        if (wr_en[l]) begin
          lvt[regIdRn2[l*IDW +: AW]] <= LW'(l);
        end
      end
    end
  end

  // Bank contents are not reset; the clear sequencer zeroes bank 0 and points the LVT at it.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      bank[0][cnt] <= '0;
    end else begin
      for (int l = 0; l < NLANES; l++) begin
        if (wr_en[l]) begin
          bank[l][regIdRn2[l*IDW +: AW]] <= regValRn2[l*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin : read_ports
    logic [IDW-1:0]   id;
    logic             zz;
    logic [32:0]      imm;
    logic [WIDTH-1:0] val;
    int               lane;
    regValRd = '0;
    for (int p = 0; p < NRDPORT; p++) begin
      id   = regIdRd[p*IDW +: IDW];
      lane = (p / 2 < NLANES) ? p / 2 : NLANES - 1;
      imm  = regValImm[lane*33 +: 33];
      zz   = 1'b0;
      val  = '0;
      if (id < IDW'(NREG)) begin
        if (!busy) begin
          val = bank[lvt[id[AW-1:0]]][id[AW-1:0]];
        end
      end else if (id == ID_IMM) begin
        val = {{(WIDTH-33){imm[32]}}, imm};
        zz  = 1'b1;
      end else if (id == ID_ZZR) begin
        zz  = 1'b1;
      end
      // Later matches override earlier ones: lane0 EX2 lowest, last lane EX1 highest.
      if (!zz && !busy) begin
        for (int l = 0; l < NLANES; l++) begin
          if (id == regIdRn2[l*IDW +: IDW]) val = regValRn2[l*WIDTH +: WIDTH];
          if (id == regIdRn1[l*IDW +: IDW]) val = regValRn1[l*WIDTH +: WIDTH];
        end
      end
      regValRd[p*WIDTH +: WIDTH] = val;
    end
  end

endmodule

// File: tb/tb_regfile_lvt_nlane.sv
// tb/tb_regfile_lvt_nlane.sv - directed self-checking bench for regfile_lvt_nlane
module tb_regfile_lvt_nlane;

  localparam int NL = 3;
  localparam int NP = 6;
  localparam int NR = 32;
  localparam int W  = 64;
  localparam int IW = 6;

  logic              clock  = 1'b0;
  logic              reset  = 1'b0;
  logic              hold   = 1'b0;
  logic              clrReq = 1'b0;
  logic              busy;
  logic [NP*IW-1:0]  regIdRd;
  logic [NP*W-1:0]   regValRd;
  logic [NL*33-1:0]  regValImm;
  logic [NL*IW-1:0]  regIdRn1;
  logic [NL*W-1:0]   regValRn1;
  logic [NL*IW-1:0]  regIdRn2;
  logic [NL*W-1:0]   regValRn2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regfile_lvt_nlane #(
    .NLANES(NL), .NRDPORT(NP), .NREG(NR), .WIDTH(W), .IDW(IW),
    .ID_IMM(6'h3E), .ID_ZZR(6'h3F)
  ) dut (
    .clock(clock), .reset(reset), .hold(hold), .clrReq(clrReq), .busy(busy),
    .regIdRd(regIdRd), .regValRd(regValRd), .regValImm(regValImm),
    .regIdRn1(regIdRn1), .regValRn1(regValRn1),
    .regIdRn2(regIdRn2), .regValRn2(regValRn2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [5:0] id);
    regIdRd[p*IW +: IW] = id;
  endtask

  function automatic logic [63:0] rd(input int p);
    return regValRd[p*W +: W];
  endfunction

  task automatic set_rn1(input int l, input logic [5:0] id, input logic [63:0] v);
    regIdRn1[l*IW +: IW] = id;
    regValRn1[l*W +: W]  = v;
  endtask

  task automatic set_rn2(input int l, input logic [5:0] id, input logic [63:0] v);
    regIdRn2[l*IW +: IW] = id;
    regValRn2[l*W +: W]  = v;
  endtask

  task automatic idle_rn();
    regIdRn1  = {NL{6'h3F}};
    regIdRn2  = {NL{6'h3F}};
    regValRn1 = '0;
    regValRn2 = '0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int nz;
    regIdRd   = {NP{6'd5}};
    regValImm = '0;
    idle_rn();
    tick();
    tick();
    check("busy_in_reset", 64'(busy), 64'd1);

    // Post-reset clear: EX1 on R5 must not bypass while busy.
    set_rn1(0, 6'd5, 64'hDEAD);
    reset = 1'b1;
    n  = 0;
    nz = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (rd(0) !== 64'd0) nz++;
      tick();
    end
    check("init_busy_cycles", 64'(n), 64'd32);
    check("init_read_zero", 64'(nz), 64'd0);
    check("init_busy_low", 64'(busy), 64'd0);
    idle_rn();
    nz = 0;
    for (int r = 0; r < NR; r++) begin
      set_rd(0, 6'(r));
      #1;
      if (rd(0) !== 64'd0) nz++;
    end
    check("gpr_all_zero", 64'(nz), 64'd0);

    // Same-edge double write: highest lane wins.
    set_rd(0, 6'd7);
    set_rn2(1, 6'd7, 64'hAAAA);
    set_rn2(2, 6'd7, 64'h5555);
    #1 check("fwd_two_lanes", rd(0), 64'h5555);
    tick();
    idle_rn();
    #1 check("lvt_highest_lane", rd(0), 64'h5555);

    // Bypass priority.
    set_rd(1, 6'd9);
    set_rn2(0, 6'd9, 64'd1);
    set_rn1(0, 6'd9, 64'd2);
    set_rn2(2, 6'd9, 64'd3);
    #1 check("fwd_l2ex2_top", rd(1), 64'd3);
    set_rn1(1, 6'd9, 64'd4);
    #1 check("fwd_l2ex2_over_l1ex1", rd(1), 64'd3);
    set_rn1(1, 6'h3F, 64'd0);
    set_rn2(2, 6'h3F, 64'd0);
    #1 check("fwd_l0ex1", rd(1), 64'd2);
    set_rn1(0, 6'h3F, 64'd0);
    #1 check("fwd_l0ex2", rd(1), 64'd1);
    idle_rn();

    // Immediate, zero register and out-of-range IDs.
    regValImm[1*33 +: 33] = 33'h1_FFFF_FFF0;
    set_rd(3, 6'h3E);
    set_rn1(0, 6'h3E, 64'h1111);
    #1 check("imm_neg_no_fwd", rd(3), 64'hFFFF_FFFF_FFFF_FFF0);
    set_rd(3, 6'h3F);
    set_rn1(0, 6'h3F, 64'h2222);
    #1 check("zzr_no_fwd", rd(3), 64'd0);
    regValImm[2*33 +: 33] = 33'h0_1234_5678;
    set_rd(5, 6'h3E);
    #1 check("imm_pos_lane2", rd(5), 64'h1234_5678);
    set_rd(2, 6'h20);
    #1 check("oor_zero", rd(2), 64'd0);
    set_rn1(1, 6'h20, 64'h99);
    #1 check("oor_fwd", rd(2), 64'h99);
    idle_rn();

    // Hold blocks writeback; IDs beyond NREG are dropped by the array.
    set_rd(0, 6'd3);
    hold = 1'b1;
    set_rn2(0, 6'd3, 64'h1234);
    tick();
    idle_rn();
    hold = 1'b0;
    #1 check("hold_blocks_write", rd(0), 64'd0);
    set_rn2(0, 6'd3, 64'h1234);
    tick();
    idle_rn();
    #1 check("write_r3", rd(0), 64'h1234);
    set_rn2(0, 6'h23, 64'hBAD);
    tick();
    idle_rn();
    #1 check("oor_write_dropped", rd(0), 64'h1234);

    // On-demand clear.
    set_rn2(2, 6'd4, 64'h77);
    tick();
    idle_rn();
    set_rd(0, 6'd4);
    #1 check("write_r4", rd(0), 64'h77);
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    check("clr_busy_rise", 64'(busy), 64'd1);
    check("clr_read_zero", rd(0), 64'd0);
    wait_clear(n);
    check("clr_busy_cycles", 64'(n), 64'd32);
    #1 check("clr_r4_zero", rd(0), 64'd0);
    set_rd(0, 6'd3);
    #1 check("clr_r3_zero", rd(0), 64'd0);

    // Reset during clear restarts the sequence.
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    #1 check("midclr_reset_busy", 64'(busy), 64'd1);
    tick();
    reset = 1'b1;
    wait_clear(n);
    check("midclr_restart_cycles", 64'(n), 64'd32);

    // Async reset during RUN discards the LVT.
    set_rn2(1, 6'd10, 64'hBEEF);
    tick();
    idle_rn();
    set_rd(0, 6'd10);
    #1 check("write_r10", rd(0), 64'hBEEF);
    reset = 1'b0;
    #1 check("async_reset_busy", 64'(busy), 64'd1);
    check("async_reset_read", rd(0), 64'd0);
    tick();
    reset = 1'b1;
    wait_clear(n);
    check("run_reset_cycles", 64'(n), 64'd32);
    #1 check("run_reset_r10_zero", rd(0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
